// File: rtl/pong_pkg.sv
// Shared definitions for the pong graphics block.
//   - FSM state type (IDLE / PLAY)
//   - geometry constants: frame-tick position, wall, paddle, ball, step sizes
//   - 12-bit colour constants (4 bits per channel, R in the MSBs)
//   - small helpers for the pixel range tests
package pong_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    // Raster position that marks the start of vertical blanking.
    localparam logic [10:0] TICK_HC     = 11'd0;
    localparam logic [10:0] TICK_VC     = 11'd480;

    // Left wall column span.
    localparam logic [9:0]  WALL_X_L    = 10'd32;
    localparam logic [9:0]  WALL_X_R    = 10'd35;

    // Paddle: fixed column span, 72 rows tall, moves 4 lines per frame.
    localparam logic [9:0]  PAD_X_L     = 10'd600;
    localparam logic [9:0]  PAD_X_R     = 10'd603;
    localparam logic [9:0]  PAD_H       = 10'd72;
    localparam logic [9:0]  PAD_LAST    = 10'd71;
    localparam logic [9:0]  PAD_STEP    = 10'd4;
    localparam logic [9:0]  PAD_Y_RST   = 10'd204;
    localparam logic [9:0]  PAD_Y_BOT   = 10'd476;

    // Ball: 8x8, moves 2 pixels per frame on each axis.
    localparam logic [9:0]  BALL_LAST   = 10'd7;
    localparam logic [9:0]  BALL_STEP   = 10'd2;
    localparam logic [9:0]  BALL_X_RST  = 10'd320;
    localparam logic [9:0]  BALL_Y_RST  = 10'd240;
    localparam logic [9:0]  BALL_Y_TOP  = 10'd2;
    localparam logic [9:0]  BALL_Y_BOT  = 10'd477;
    localparam logic [9:0]  BALL_X_WALL = 10'd36;
    localparam logic [9:0]  BALL_X_MISS = 10'd639;

    localparam logic [11:0] COL_BALL    = 12'hF00;
    localparam logic [11:0] COL_PADDLE  = 12'h0F0;
    localparam logic [11:0] COL_WALL    = 12'h00F;
    localparam logic [11:0] COL_BG      = 12'h000;

    // Widen a 10-bit object coordinate to raster-counter width.
    function automatic logic [10:0] ext(input logic [9:0] v);
        return {1'b0, v};
    endfunction

    // Inclusive range test on raster coordinates.
    function automatic logic in_span(input logic [10:0] p,
                                     input logic [10:0] lo,
                                     input logic [10:0] hi);
        return (p >= lo) && (p <= hi);
    endfunction

endpackage

// File: rtl/pong_tick_gen.sv
// Frame tick generator.
// The raster counters hold each (hc, vc) value for several clocks, so the
// tick is produced from the rising edge of the "at (0,480)" match.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high
//   hc    - current pixel column (11 bits)
//   vc    - current pixel line (11 bits)
//   tick  - one-clk pulse on the first clk where hc==0 and vc==480
module pong_tick_gen
    import pong_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hc,
    input  logic [10:0] vc,
    output logic        tick
);

    logic hit_d, hit_q;
    logic rst_seen_d, rst_seen_q;

    always_comb begin
        hit_d      = (hc == TICK_HC) && (vc == TICK_VC);
        rst_seen_d = 1'b0;
        // The edge register is cleared in reset, so the first clk after
        // release is masked; otherwise a held (0,480) would look like an edge.
        tick       = hit_d && !hit_q && !rst_seen_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q      <= 1'b0;
            rst_seen_q <= 1'b1;
        end else begin
            hit_q      <= hit_d;
            rst_seen_q <= rst_seen_d;
        end
    end

endmodule

// File: rtl/pong_graph.sv
// Pong game object logic and pixel generator.
// Holds the paddle, the ball and the IDLE/PLAY state, updates them once per
// frame, and produces a registered pixel colour for the current (hc, vc).
// Optional feature: define PONG_MISS_CNT_EN to build the 4-bit miss counter;
// without it `miss` is tied to 0 (misses still recentre the ball).
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high
//   btn   - paddle buttons, btn[0]=up, btn[1]=down (debounced, clk-synchronous)
//   hc    - current pixel column (0..799)
//   vc    - current pixel line (0..524)
//   rgb   - pixel colour, 1 clk after hc/vc
//   miss  - number of balls missed, wraps 15->0
module pong_graph
    import pong_pkg::*;
#(
    parameter int CD = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    btn,
    input  logic [10:0]   hc,
    input  logic [10:0]   vc,
    output logic [CD-1:0] rgb,
    output logic [3:0]    miss
);

    logic          tick;
    state_t        state_d,    state_q;
    logic [9:0]    paddle_y_d, paddle_y_q;
    logic [9:0]    ball_x_d,   ball_x_q;
    logic [9:0]    ball_y_d,   ball_y_q;
    logic          vx_neg_d,   vx_neg_q;   // 1: vx = -2, 0: vx = +2
    logic          vy_neg_d,   vy_neg_q;   // 1: vy = -2, 0: vy = +2
    logic [CD-1:0] rgb_d,      rgb_q;
    logic          miss_hit;
    logic          paddle_face;
    logic          rows_overlap;
    logic          ball_on, paddle_on, wall_on;

    pong_tick_gen u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .hc    (hc),
        .vc    (vc),
        .tick  (tick)
    );

    always_comb begin
        // NOTE: every always_comb output is given a default first so no
        // path through the block leaves it unassigned (no latches).
        state_d      = state_q;
        paddle_y_d   = paddle_y_q;
        ball_x_d     = ball_x_q;
        ball_y_d     = ball_y_q;
        vx_neg_d     = vx_neg_q;
        vy_neg_d     = vy_neg_q;

        // Miss is evaluated first and overrides every bounce rule.
        miss_hit     = tick && (state_q == ST_PLAY) &&
                       (ball_x_q + BALL_LAST >= BALL_X_MISS);
        paddle_face  = in_span(ext(ball_x_q + BALL_LAST), ext(PAD_X_L), ext(PAD_X_R));
        rows_overlap = (ball_y_q + BALL_LAST >= paddle_y_q) &&
                       (ball_y_q <= paddle_y_q + PAD_LAST);

        if (tick) begin
            // Paddle moves regardless of game state; both buttons = no move.
            if (btn == 2'b01 && paddle_y_q >= PAD_STEP)
                paddle_y_d = paddle_y_q - PAD_STEP;
            else if (btn == 2'b10 && paddle_y_q + PAD_H <= PAD_Y_BOT)
                paddle_y_d = paddle_y_q + PAD_STEP;

            if (miss_hit) begin
                state_d  = ST_IDLE;
                ball_x_d = BALL_X_RST;
                ball_y_d = BALL_Y_RST;
                vx_neg_d = 1'b1;
                vy_neg_d = 1'b0;
            end else if (state_q == ST_IDLE) begin
                if (btn != 2'b00)
                    state_d = ST_PLAY;
            end else begin
                // Move with the current velocity; the new velocity is decided
                // from the pre-move position and takes effect next frame.
                ball_x_d = vx_neg_q ? ball_x_q - BALL_STEP : ball_x_q + BALL_STEP;
                ball_y_d = vy_neg_q ? ball_y_q - BALL_STEP : ball_y_q + BALL_STEP;

                if (ball_y_q <= BALL_Y_TOP)
                    vy_neg_d = 1'b0;
                else if (ball_y_q + BALL_LAST >= BALL_Y_BOT)
                    vy_neg_d = 1'b1;

                if (ball_x_q <= BALL_X_WALL)
                    vx_neg_d = 1'b0;
                else if (!vx_neg_q && paddle_face && rows_overlap)
                    vx_neg_d = 1'b1;
            end
        end
    end

    // Pixel colour: ball > paddle > wall > background.
    always_comb begin
        ball_on   = (state_q == ST_PLAY) &&
                    in_span(hc, ext(ball_x_q), ext(ball_x_q + BALL_LAST)) &&
                    in_span(vc, ext(ball_y_q), ext(ball_y_q + BALL_LAST));
        paddle_on = in_span(hc, ext(PAD_X_L), ext(PAD_X_R)) &&
                    in_span(vc, ext(paddle_y_q), ext(paddle_y_q + PAD_LAST));
        wall_on   = in_span(hc, ext(WALL_X_L), ext(WALL_X_R));

        if (ball_on)
            rgb_d = CD'(COL_BALL);
        else if (paddle_on)
            rgb_d = CD'(COL_PADDLE);
        else if (wall_on)
            rgb_d = CD'(COL_WALL);
        else
            rgb_d = CD'(COL_BG);
    end

`ifdef PONG_MISS_CNT_EN
    logic [3:0] miss_d, miss_q;

    always_comb begin
        miss_d = miss_hit ? miss_q + 4'd1 : miss_q;
    end

    always_ff @(posedge clk) begin
        if (reset)
            miss_q <= 4'd0;
        else
            miss_q <= miss_d;
    end

    assign miss = miss_q;
`else
    assign miss = 4'd0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            paddle_y_q <= PAD_Y_RST;
            ball_x_q   <= BALL_X_RST;
            ball_y_q   <= BALL_Y_RST;
            vx_neg_q   <= 1'b0;
            vy_neg_q   <= 1'b0;
            rgb_q      <= '0;
        end else begin
            state_q    <= state_d;
            paddle_y_q <= paddle_y_d;
            ball_x_q   <= ball_x_d;
            ball_y_q   <= ball_y_d;
            vx_neg_q   <= vx_neg_d;
            vy_neg_q   <= vy_neg_d;
            rgb_q      <= rgb_d;
        end
    end

    assign rgb = rgb_q;

endmodule

// File: tb/tb_pong_graph.sv
// Directed testbench for pong_graph. The raster position is driven directly:
// a frame tick is produced by parking hc/vc on (0,480) for two clks, and
// object positions are observed through the colour of chosen pixels.
module tb_pong_graph;

    localparam logic [11:0] RED = 12'hF00;
    localparam logic [11:0] GRN = 12'h0F0;
    localparam logic [11:0] BLU = 12'h00F;
    localparam logic [11:0] BLK = 12'h000;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  btn;
    logic [10:0] hc;
    logic [10:0] vc;
    logic [11:0] rgb;
    logic [3:0]  miss;

    int n_checks = 0;
    int n_errors = 0;

    pong_graph #(.CD(12)) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .hc    (hc),
        .vc    (vc),
        .rgb   (rgb),
        .miss  (miss)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clk; inputs change and outputs are read 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            hc = 11'd0;
            vc = 11'd480;
            step();
            step();
            hc = 11'd1;
            step();
        end
    endtask

    task automatic px(input string tag, input int x, input int y, input logic [11:0] exp);
        hc = x[10:0];
        vc = y[10:0];
        step();
        check(tag, rgb, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        btn   = 2'b00;
        hc    = 11'd100;
        vc    = 11'd100;
        repeat (3) step();
        reset = 1'b0;
        step();
    endtask

    function automatic int exp_miss(input int n);
`ifdef PONG_MISS_CNT_EN
        return n % 16;
`else
        return 0;
`endif
    endfunction

    initial begin
        reset = 1'b1;
        btn   = 2'b00;
        hc    = 11'd33;
        vc    = 11'd100;
        repeat (3) step();
        check("rgb_in_reset", rgb, BLK);
        check("miss_in_reset", miss, 0);

        // Release reset while parked on (0,480) with up pressed: no tick.
        btn = 2'b01;
        hc  = 11'd0;
        vc  = 11'd480;
        step();
        reset = 1'b0;
        repeat (4) step();
        hc = 11'd1;
        step();
        px("no_tick_pad_top", 601, 204, GRN);
        px("no_tick_pad_above", 601, 203, BLK);
        px("idle_ball_hidden", 320, 240, BLK);
        px("wall", 33, 100, BLU);
        px("wall_right_edge", 36, 100, BLK);
        px("background", 100, 100, BLK);

        // Start with both buttons: PLAY, paddle unchanged, ball shown at reset spot.
        btn = 2'b11;
        ticks(1);
        px("start_ball_tl", 320, 240, RED);
        px("start_ball_br", 327, 247, RED);
        px("start_ball_right", 328, 240, BLK);
        px("start_ball_left", 319, 240, BLK);
        px("paddle_600_210", 600, 210, GRN);
        px("paddle_left_edge", 599, 210, BLK);
        px("paddle_right_edge", 604, 210, BLK);
        ticks(2);
        px("both_btn_pad", 601, 204, GRN);
        px("both_btn_pad_above", 601, 203, BLK);
        px("move2_ball", 324, 244, RED);
        px("move2_ball_left", 323, 244, BLK);
        px("move2_ball_up", 324, 243, BLK);

        // Paddle up: 50 ticks -> 4, 51 -> 0, then pinned at 0.
        btn = 2'b01;
        ticks(50);
        px("up50_pad", 601, 4, GRN);
        px("up50_above", 601, 3, BLK);
        ticks(1);
        px("up51_pad_top", 601, 0, GRN);
        px("up51_pad_bot", 601, 71, GRN);
        px("up51_below", 601, 72, BLK);
        ticks(9);
        px("up60_pad_top", 601, 0, GRN);
        px("up60_below", 601, 72, BLK);
        px("up60_ball", 444, 364, RED);
        px("up60_ball_left", 443, 364, BLK);

        // Paddle down limit: 404 still moves, 408 stays.
        do_reset();
        btn = 2'b10;
        ticks(50);
        px("dn_pad_404", 601, 404, GRN);
        px("dn_pad_403", 601, 403, BLK);
        ticks(1);
        px("dn_pad_408", 601, 408, GRN);
        px("dn_pad_407", 601, 407, BLK);
        ticks(5);
        px("dn_hold_408", 601, 408, GRN);
        px("dn_hold_407", 601, 407, BLK);
        px("dn_hold_479", 601, 479, GRN);
        px("dn_ball", 430, 350, RED);

        // Bottom bounce and a miss with the paddle away from the ball.
        do_reset();
        btn = 2'b11;
        ticks(1);
        btn = 2'b00;
        ticks(115);
        px("y470_ball", 550, 470, RED);
        px("y470_above", 550, 469, BLK);
        ticks(1);
        px("y472_ball_bot", 552, 479, RED);
        px("y472_above", 552, 471, BLK);
        ticks(1);
        px("y470b_ball_bot", 554, 477, RED);
        px("y470b_below", 554, 478, BLK);
        ticks(39);
        px("x632_ball", 632, 392, RED);
        px("x632_left", 631, 392, BLK);
        check("miss_before", miss, 0);
        ticks(1);
        px("miss_ball_gone", 632, 392, BLK);
        px("miss_hidden_ctr", 320, 240, BLK);
        check("miss_after_1", miss, exp_miss(1));

        // Restart (vx=-2): wall bounce, top bounce, paddle bounce.
        btn = 2'b11;
        ticks(1);
        btn = 2'b00;
        ticks(142);
        px("x36_ball", 36, 420, RED);
        px("x36_wall", 35, 420, BLU);
        ticks(1);
        px("x34_ball_over_wall", 34, 418, RED);
        px("x34_wall", 33, 418, BLU);
        ticks(2);
        px("x38_ball", 38, 414, RED);
        px("x38_left", 37, 414, BLK);
        btn = 2'b01;
        ticks(16);
        btn = 2'b00;
        ticks(191);
        px("top_ball", 452, 0, RED);
        px("top_below", 452, 8, BLK);
        px("pad140_top", 601, 140, GRN);
        px("pad140_above", 601, 139, BLK);
        ticks(71);
        px("x594_ball", 594, 142, RED);
        px("x594_left", 593, 142, BLK);
        ticks(1);
        px("x596_ball", 596, 144, RED);
        px("ball_over_paddle", 601, 150, RED);
        px("x596_right", 604, 144, BLK);
        ticks(1);
        px("bounced_ball", 594, 146, RED);
        px("bounced_paddle", 602, 146, GRN);
        px("bounced_left", 593, 146, BLK);

        // Sixteen misses from reset; counter wraps back to 0.
        do_reset();
        btn = 2'b11;
        ticks(1);
        btn = 2'b00;
        ticks(157);
        check("wrap_miss_1", miss, exp_miss(1));
        for (int i = 2; i <= 16; i++) begin
            btn = 2'b11;
            ticks(1);
            btn = 2'b00;
            ticks(443);
            check($sformatf("wrap_miss_%0d", i), miss, exp_miss(i));
        end
        px("wrap_ball_hidden", 320, 240, BLK);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pong_graph.md
PONG_GRAPH -- requirements
Module: pong_graph

Interface
REQ-001 SHALL have parameter CD, default 12, meaning RGB colour depth in bits (4 bits per channel, R in MSBs).
REQ-002 SHALL have port clk  input  1  system clock; the design has one clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port btn  input  2  debounced, clk-synchronous paddle buttons; btn[0]=up, btn[1]=down.
REQ-005 SHALL have port hc  input  11  current pixel column from the VGA sync stage (0..799).
REQ-006 SHALL have port vc  input  11  current pixel line from the VGA sync stage (0..524).
REQ-007 SHALL have port rgb  output  CD  pixel colour streamed to the VGA sync stage's stream input.
REQ-008 SHALL have port miss  output  4  count of balls missed.

Function
REQ-009 SHALL generate a one-clk frame_tick on the first clk where hc==0 and vc==480; hc holds each value for several clks, so the tick SHALL come from edge detection.
REQ-010 SHALL hold paddle_y (10-bit, paddle top) with paddle x 600..603 and height 72.
REQ-011 On frame_tick, up only: paddle_y -= 4 when paddle_y >= 4, else unchanged.
REQ-012 On frame_tick, down only: paddle_y += 4 when paddle_y+72 <= 476, else unchanged.
REQ-013 On frame_tick, both or neither button pressed: paddle_y unchanged.
REQ-014 SHALL hold an 8x8 ball at ball_x, ball_y (10-bit, top-left) with velocity vx, vy in {+2,-2}.
REQ-015 SHALL run FSM states IDLE, PLAY; IDLE -> PLAY on frame_tick when btn != 0; ball hidden in IDLE.
REQ-016 In PLAY on frame_tick, ball SHALL move by the current vx, vy; new velocity SHALL be decided from the pre-move position.
REQ-017 vy SHALL become +2 when ball_y <= 2, and -2 when ball_y+7 >= 477.
REQ-018 vx SHALL become +2 when ball_x <= 36 (wall occupies x 32..35).
REQ-019 vx SHALL become -2 when vx == +2, ball_x+7 is in 600..603 and ball rows overlap paddle rows (ball_y+7 >= paddle_y and ball_y <= paddle_y+71).
REQ-020 Miss: in PLAY on frame_tick, when ball_x+7 >= 639, FSM SHALL go to IDLE, ball SHALL reset to (320,240), vx=-2, vy=+2, and miss SHALL increment, wrapping 15->0.
REQ-021 Miss SHALL take priority over every bounce rule in the same tick.
REQ-022 Pixel colour priority, outputs: ball 12'hF00 (PLAY only) > paddle 12'h0F0 > wall 12'h00F > background 12'h000.
REQ-023 rgb SHALL be registered with 1-clk latency from hc/vc; values outside 640x480 are don't-care, because the downstream stage blanks them.

Reset
REQ-024 While reset=1 at a clk edge: state=IDLE, paddle_y=204, ball=(320,240), vx=+2, vy=+2, miss=0, rgb=0, edge-detect register cleared.
REQ-025 Reset asserted mid-frame or mid-tick SHALL override all updates that cycle; no frame_tick SHALL be produced in the cycle reset deasserts.

Configuration
REQ-026 With PONG_MISS_CNT_EN defined, miss SHALL behave as described in REQ-020.
REQ-027 With PONG_MISS_CNT_EN undefined, miss SHALL be constant 0 and no counter register SHALL exist; miss still triggers IDLE and recentring.

Structure
REQ-028 Package pong_pkg SHALL hold geometry constants (wall, paddle, ball sizes/positions, step sizes), colour constants and the FSM state typedef.
REQ-029 Frame-tick edge detection SHALL be sub-module pong_tick_gen (inputs clk, reset, hc, vc; output tick).

Verification
REQ-030 hc/vc sweep, reset then released -> exactly one frame_tick per 800x525 frame, at first clk of hc=0,vc=480.
REQ-031 btn=01 held 60 frames from reset -> paddle_y reaches 0 after 51 ticks and stays 0; btn=11 -> paddle_y stays 204.
REQ-032 PLAY, ball descending, ball_y=470 -> next tick vy=-2 and ball_y=472; the following tick ball_y=470.
REQ-033 ball_x=593, vx=+2, paddle_y=204, ball_y=240 -> vx=-2 after tick; same with paddle_y=0 -> miss increments on reaching ball_x+7>=639, state IDLE.
REQ-034 Pixel (600,210) sampled with paddle_y=204 -> rgb=12'h0F0 one clk later; ball overlapping paddle pixel -> 12'hF00.
REQ-035 16 misses with PONG_MISS_CNT_EN -> miss wraps to 0; without macro -> miss stays 0 throughout.
